// File: rtl/arm_dmem_pkg.sv
// Package: arm_dmem_pkg
// Shared types and constants for the ARM data-memory access controller.
//   dmem_state_t : controller FSM states (IDLE, WAIT, DONE)
//   ERR_DATA     : load data returned when an access times out
//   LOAD_MASK    : byte write mask that identifies a load
package arm_dmem_pkg;

  typedef enum logic [1:0] {
    DM_IDLE,
    DM_WAIT,
    DM_DONE
  } dmem_state_t;

  localparam logic [31:0] ERR_DATA  = 32'hDEADBEEF;
  localparam logic [3:0]  LOAD_MASK = 4'b0000;

endpackage

// File: rtl/arm_dmem_timer.sv
// Module: arm_dmem_timer
// Bus-wait timeout counter for arm_dmem_ctrl.
// Ports:
//   clk, rst_b : clock, async active-low reset
//   clr        : restart count at zero (access enters WAIT)
//   en         : count one WAIT cycle that saw no ack
//   expired    : count has reached TIMEOUT_CYCLES-1, i.e. the current WAIT
//                cycle is the last one allowed
module arm_dmem_timer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic clk,
  input  logic rst_b,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)   count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + CNT_W'(1);
  end

  assign expired = (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/arm_dmem_ctrl.sv
// Module: arm_dmem_ctrl
// Turns the single-cycle core's load/store into a req/ack transaction on a
// variable-latency memory bus and stalls the core until it completes.
// Ports:
//   clk, rst_b                        : clock, async active-low reset
//   halted                            : core halted, new requests ignored
//   core_req/addr/we/wdata            : access presented by the core
//   core_rdata, core_err              : load result / timeout flag, valid in DONE
//   core_stall                        : hold core state updates this cycle
//   bus_req/addr/we/wdata             : registered bus request and latched fields
//   bus_ack, bus_rdata                : completion pulse and read data from memory
// Configuration: define ARM_DMEM_TIMEOUT_EN to bound WAIT by TIMEOUT_CYCLES
// and report core_err; otherwise WAIT is unbounded and core_err is 0.
module arm_dmem_ctrl
  import arm_dmem_pkg::*;
#(
  parameter int ADDR_W         = 30,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              halted,
  input  logic              core_req,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [3:0]        core_we,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  output logic              core_err,
  output logic              bus_req,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_we,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
);

  // The timeout counter must be able to represent TIMEOUT_CYCLES-1.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << CNT_W)) begin : g_bad_cfg
    $error("arm_dmem_ctrl: TIMEOUT_CYCLES does not fit in CNT_W bits");
  end

  dmem_state_t state, state_nx;
  logic        start;     // IDLE -> WAIT: latch request
  logic        ack_done;  // WAIT completed by bus ack
  logic        timeout;   // WAIT abandoned by timer expiry
  logic        expired;
  logic        is_load;

  assign is_load = (bus_we == LOAD_MASK);

  // NOTE: every output of this combinational block gets a default first, so
  // no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nx   = state;
    core_stall = 1'b0;
    start      = 1'b0;
    ack_done   = 1'b0;
    timeout    = 1'b0;
    unique case (state)
      DM_IDLE: begin
        core_stall = core_req & ~halted;
        if (core_req && !halted) begin
          start    = 1'b1;
          state_nx = DM_WAIT;
        end
      end
      DM_WAIT: begin
        core_stall = 1'b1;
        // Ack on the expiry cycle is a normal completion.
        if (bus_ack) begin
          ack_done = 1'b1;
          state_nx = DM_DONE;
        end else if (expired) begin
          timeout  = 1'b1;
          state_nx = DM_DONE;
        end
      end
      // One unstalled cycle lets the core retire; returning to IDLE
      // unconditionally keeps the still-presented request from re-issuing.
      DM_DONE: state_nx = DM_IDLE;
      default: state_nx = DM_IDLE;
    endcase
  end

  // Async reset clears bus_req at assertion, aborting any open access.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= DM_IDLE;
      bus_req    <= 1'b0;
      bus_addr   <= '0;
      bus_we     <= '0;
      bus_wdata  <= '0;
      core_rdata <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        bus_req   <= 1'b1;
        bus_addr  <= core_addr;
        bus_we    <= core_we;
        bus_wdata <= core_wdata;
      end else if (ack_done || timeout) begin
        bus_req <= 1'b0;
      end
      // Stores leave core_rdata holding the last load result.
      if (ack_done && is_load)     core_rdata <= bus_rdata;
      else if (timeout && is_load) core_rdata <= DATA_W'(ERR_DATA);
    end
  end

`ifdef ARM_DMEM_TIMEOUT_EN
  arm_dmem_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst_b   (rst_b),
    .clr     (start),
    .en      ((state == DM_WAIT) && !bus_ack),
    .expired (expired)
  );

  // Error persists through DONE and IDLE until the next access starts.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)                 core_err <= 1'b0;
    else if (start || ack_done) core_err <= 1'b0;
    else if (timeout)           core_err <= 1'b1;
  end
`else
  assign expired  = 1'b0;
  assign core_err = 1'b0;
`endif

endmodule

// File: tb/tb_arm_dmem_ctrl.sv
// Testbench for arm_dmem_ctrl. Acts as the core and as the memory; expected
// load results are queued when a request is presented and compared when the
// controller reaches its retire (DONE) cycle. Timeout scenarios run only when
// ARM_DMEM_TIMEOUT_EN is defined.
module tb_arm_dmem_ctrl;

  localparam int TMO = 8;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        halted;
  logic        core_req;
  logic [29:0] core_addr;
  logic [3:0]  core_we;
  logic [31:0] core_wdata;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        core_err;
  logic        bus_req;
  logic [29:0] bus_addr;
  logic [3:0]  bus_we;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int   tests  = 0;
  int   errors = 0;
  exp_t sb_q[$];
  logic [31:0] model_rdata;

  always #5 clk = ~clk;

  arm_dmem_ctrl #(
    .ADDR_W(30), .DATA_W(32), .TIMEOUT_CYCLES(TMO), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_b(rst_b), .halted(halted),
    .core_req(core_req), .core_addr(core_addr), .core_we(core_we),
    .core_wdata(core_wdata), .core_rdata(core_rdata),
    .core_stall(core_stall), .core_err(core_err),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_we(bus_we),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One core access, starting in an IDLE cycle at a negedge. ack_at = WAIT
  // cycle (1-based) in which memory acks; 0 = never. Ends in the following
  // IDLE cycle with core_req dropped.
  task automatic access(input logic [29:0] a, input logic [3:0] we,
                        input logic [31:0] wd, input logic [31:0] rd,
                        input int ack_at, input bit exp_err);
    int   w;
    int   exp_w;
    exp_t e;
    exp_t got;
    core_req = 1'b1; core_addr = a; core_we = we; core_wdata = wd;
    #1 check("idle_stall", 32'(core_stall), 32'd1);
    if (we == 4'b0000) model_rdata = exp_err ? 32'hDEADBEEF : rd;
    e.rdata = model_rdata;
    e.err   = exp_err;
    sb_q.push_back(e);
    exp_w = exp_err ? TMO : ack_at;
    w = 0;
    @(negedge clk);
    while (core_stall && w < 40) begin
      w++;
      check("wait_bus_req",  32'(bus_req), 32'd1);
      check("wait_bus_addr", 32'(bus_addr), 32'(a));
      check("wait_bus_we",   32'(bus_we), 32'(we));
      check("wait_bus_wdata", bus_wdata, wd);
      bus_ack   = (w == ack_at);
      bus_rdata = (w == ack_at) ? rd : $urandom;
      @(negedge clk);
      bus_ack = 1'b0;
    end
    // Retire cycle.
    check("wait_cycles", 32'(w), 32'(exp_w));
    check("done_bus_req", 32'(bus_req), 32'd0);
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      got = sb_q.pop_front();
      check("done_rdata", core_rdata, got.rdata);
      check("done_err", 32'(core_err), 32'(got.err));
    end
    core_req = 1'b0;
    @(negedge clk);
    check("post_bus_req", 32'(bus_req), 32'd0);
    check("post_stall", 32'(core_stall), 32'd0);
  endtask

  initial begin
    rst_b = 1'b0; halted = 1'b0; core_req = 1'b0; core_addr = '0;
    core_we = '0; core_wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
    model_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_rdata", core_rdata, 32'd0);
    check("rst_err", 32'(core_err), 32'd0);
    check("rst_bus_addr", 32'(bus_addr), 32'd0);
    rst_b = 1'b1;
    @(negedge clk);

    // Load, immediate ack.
    access(30'h004, 4'b0000, 32'h0, 32'h12345678, 1, 1'b0);
    // Store, ack in 4th WAIT cycle; core_rdata keeps previous load value.
    access(30'h100, 4'b0010, 32'h0000AB00, 32'hFFFFFFFF, 4, 1'b0);
    // Back-to-back load, store, load.
    access(30'h010, 4'b0000, 32'h0, 32'hCAFEF00D, 1, 1'b0);
    access(30'h011, 4'b1111, 32'h55AA55AA, 32'h0BADF00D, 1, 1'b0);
    access(30'h012, 4'b0000, 32'h0, 32'hA5A5A5A5, 1, 1'b0);

    // Halted: request ignored, stray ack ignored.
    halted = 1'b1; core_req = 1'b1; core_addr = 30'h3;
    for (int i = 0; i < 3; i++) begin
      bus_ack = (i == 1); bus_rdata = 32'h11111111;
      #1 check("halt_stall", 32'(core_stall), 32'd0);
      @(negedge clk);
      check("halt_bus_req", 32'(bus_req), 32'd0);
      check("halt_rdata", core_rdata, model_rdata);
    end
    bus_ack = 1'b0; core_req = 1'b0; halted = 1'b0;
    @(negedge clk);

    // Reset in the 2nd WAIT cycle.
    core_req = 1'b1; core_addr = 30'h2A; core_we = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    check("rstw_bus_req", 32'(bus_req), 32'd0);
    check("rstw_bus_addr", 32'(bus_addr), 32'd0);
    check("rstw_rdata", core_rdata, 32'd0);
    check("rstw_err", 32'(core_err), 32'd0);
    core_req = 1'b0;
    model_rdata = '0;
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    access(30'h2B, 4'b0000, 32'h0, 32'h87654321, 2, 1'b0);

`ifdef ARM_DMEM_TIMEOUT_EN
    // No ack: times out after TMO WAIT cycles.
    access(30'h050, 4'b0000, 32'h0, 32'h0, 0, 1'b1);
    check("tmo_err_held", 32'(core_err), 32'd1);
    // Ack on the expiry cycle wins.
    access(30'h051, 4'b0000, 32'h0, 32'h600DD00D, TMO, 1'b0);
    // Store timeout leaves core_rdata untouched.
    access(30'h052, 4'b0001, 32'h000000EE, 32'h0, 0, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
